multicycle_control: RTL and testbench

Main control FSM for the 16-bit multicycle processor. It sequences each instruction through fetch, decode, execute, memory and write-back. It drives every datapath enable and mux select, and it issues the 2-bit ALUOp that the ALU control decoder turns into an ALU operation together with the instruction funct field. It stalls on a memory ready handshake, so it works with single-cycle and multi-cycle memory alike.

---
 rtl/multicycle_control.sv | 154 +++++++++++++++
 tb/tb_multicycle_control.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// Main control FSM for the 16-bit multicycle processor.
// Sequences fetch/decode/execute/memory/write-back, drives every datapath
// enable and mux select, and stalls on the memory ready handshake.
module multicycle_control (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_en,
    output logic [1:0] pc_source,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [3:0] state,
    output logic       illegal
);

    localparam logic [3:0] OP_R    = 4'd0;
    localparam logic [3:0] OP_LW   = 4'd1;
    localparam logic [3:0] OP_SW   = 4'd2;
    localparam logic [3:0] OP_BEQ  = 4'd3;
    localparam logic [3:0] OP_BNE  = 4'd4;
    localparam logic [3:0] OP_ADDI = 4'd5;
    localparam logic [3:0] OP_J    = 4'd6;

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXEC   = 4'd6,
        ALUWB  = 4'd7,
        BRANCH = 4'd8,
        JUMP   = 4'd9,
        ADDIEX = 4'd10,
        ADDIWB = 4'd11
    } state_t;

    state_t     cur, nxt;
    logic [3:0] op_q;

    // State register; reset drops straight back to FETCH.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) cur <= FETCH;
        else        cur <= nxt;
    end

    // Capture the opcode while decoding so later states ignore IR changes.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)              op_q <= 4'd0;
        else if (cur == DECODE)  op_q <= opcode;
    end

    // Next-state and control outputs; everything stays 0 while reset is low.
    always_comb begin
        nxt        = FETCH;
        pc_en      = 1'b0;
        pc_source  = 2'b00;
        i_or_d     = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        illegal    = 1'b0;
        state      = cur;
        if (reset) begin
            case (cur)
                FETCH: begin
                    mem_read  = 1'b1;
                    alu_src_b = 2'b01;
                    ir_write  = mem_ready;
                    pc_en     = mem_ready;
                    nxt       = mem_ready ? DECODE : FETCH;
                end
                DECODE: begin
                    alu_src_b = 2'b10;
                    case (opcode)
                        OP_R:          nxt = EXEC;
                        OP_LW, OP_SW:  nxt = MEMADR;
                        OP_BEQ, OP_BNE: nxt = BRANCH;
                        OP_ADDI:       nxt = ADDIEX;
                        OP_J:          nxt = JUMP;
                        default: begin
                            illegal = 1'b1;
                            nxt     = FETCH;
                        end
                    endcase
                end
                MEMADR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                    nxt       = (op_q == OP_LW) ? MEMRD : MEMWR;
                end
                MEMRD: begin
                    mem_read = 1'b1;
                    i_or_d   = 1'b1;
                    nxt      = mem_ready ? MEMWB : MEMRD;
                end
                MEMWB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                end
                MEMWR: begin
                    mem_write = 1'b1;
                    i_or_d    = 1'b1;
                    nxt       = mem_ready ? FETCH : MEMWR;
                end
                EXEC: begin
                    alu_src_a = 1'b1;
                    alu_op    = 2'b10;
                    nxt       = ALUWB;
                end
                ALUWB: begin
                    reg_write = 1'b1;
                    reg_dst   = 1'b1;
                end
                BRANCH: begin
                    alu_src_a = 1'b1;
                    alu_op    = 2'b01;
                    pc_source = 2'b01;
                    pc_en     = (op_q == OP_BNE) ? ~zero : zero;
                end
                ADDIEX: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                    alu_op    = 2'b11;
                    nxt       = ADDIWB;
                end
                ADDIWB: reg_write = 1'b1;
                JUMP: begin
                    pc_source = 2'b10;
                    pc_en     = 1'b1;
                end
                default: nxt = FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: an instruction-level trace model
// builds the expected control word for every cycle; one compare process
// checks the DUT against it, and literal latency checks pin the model.
module tb_multicycle_control;

    localparam logic [3:0] OP_R    = 4'd0;
    localparam logic [3:0] OP_LW   = 4'd1;
    localparam logic [3:0] OP_SW   = 4'd2;
    localparam logic [3:0] OP_BEQ  = 4'd3;
    localparam logic [3:0] OP_BNE  = 4'd4;
    localparam logic [3:0] OP_ADDI = 4'd5;
    localparam logic [3:0] OP_J    = 4'd6;

    typedef struct packed {
        logic [3:0] st;
        logic       pc_en;
        logic [1:0] pc_source;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       illegal;
    } ctrl_t;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] opcode = 4'd0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       pc_en, i_or_d, mem_read, mem_write, ir_write, reg_dst;
    logic       mem_to_reg, reg_write, alu_src_a, illegal;
    logic [1:0] pc_source, alu_src_b, alu_op;
    logic [3:0] state;

    int checks = 0;
    int failures = 0;
    int trace_idx = 0;
    ctrl_t exp_q[$];
    ctrl_t act;

    multicycle_control dut (
        .clock(clock), .reset(reset), .opcode(opcode), .zero(zero),
        .mem_ready(mem_ready), .pc_en(pc_en), .pc_source(pc_source),
        .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write),
        .ir_write(ir_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_op(alu_op), .state(state), .illegal(illegal)
    );

    always #5 clock = ~clock;

    assign act = {state, pc_en, pc_source, i_or_d, mem_read, mem_write, ir_write,
                  reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op, illegal};

    // Compare every cycle that has an expectation queued.
    always @(negedge clock) begin
        if (exp_q.size() != 0) begin
            ctrl_t e;
            e = exp_q.pop_front();
            checks++;
            if (act !== e) begin
                failures++;
                $display("FAIL trace[%0d] got st=%0d ctrl=%h want st=%0d ctrl=%h",
                         trace_idx, act.st, act, e.st, e);
            end
            trace_idx++;
        end
    end

    function automatic ctrl_t blank(input logic [3:0] s);
        ctrl_t c;
        c = '0;
        c.st = s;
        return c;
    endfunction

    function automatic ctrl_t fetch_e(input logic done);
        ctrl_t c;
        c = blank(4'd0);
        c.mem_read  = 1'b1;
        c.alu_src_b = 2'b01;
        c.ir_write  = done;
        c.pc_en     = done;
        return c;
    endfunction

    // One cycle: drive inputs just after the edge and queue the expectation.
    task automatic cyc(input ctrl_t e, input logic [3:0] op, input logic rdy,
                       input logic z, input logic rst);
        @(posedge clock);
        #1;
        reset = rst;
        opcode = op;
        mem_ready = rdy;
        zero = z;
        exp_q.push_back(e);
    endtask

    // Expected trace of one instruction from the per-instruction rules.
    // The opcode is scrambled outside DECODE so only the captured copy counts.
    task automatic run_instr(input logic [3:0] op, input int fst, input int mst,
                             input logic z);
        ctrl_t e;
        logic [3:0] g;
        g = ~op;
        for (int i = 0; i < fst; i++) cyc(fetch_e(1'b0), g, 1'b0, ~z, 1'b1);
        cyc(fetch_e(1'b1), g, 1'b1, ~z, 1'b1);
        e = blank(4'd1);
        e.alu_src_b = 2'b10;
        e.illegal = (op > 4'd6);
        cyc(e, op, 1'b0, ~z, 1'b1);
        case (op)
            OP_R: begin
                e = blank(4'd6); e.alu_src_a = 1'b1; e.alu_op = 2'b10;
                cyc(e, g, 1'b0, ~z, 1'b1);
                e = blank(4'd7); e.reg_write = 1'b1; e.reg_dst = 1'b1;
                cyc(e, g, 1'b0, ~z, 1'b1);
            end
            OP_LW, OP_SW: begin
                e = blank(4'd2); e.alu_src_a = 1'b1; e.alu_src_b = 2'b10;
                cyc(e, g, 1'b0, ~z, 1'b1);
                if (op == OP_LW) begin
                    e = blank(4'd3); e.mem_read = 1'b1; e.i_or_d = 1'b1;
                end else begin
                    e = blank(4'd5); e.mem_write = 1'b1; e.i_or_d = 1'b1;
                end
                for (int i = 0; i < mst; i++) cyc(e, g, 1'b0, ~z, 1'b1);
                cyc(e, g, 1'b1, ~z, 1'b1);
                if (op == OP_LW) begin
                    e = blank(4'd4); e.reg_write = 1'b1; e.mem_to_reg = 1'b1;
                    cyc(e, g, 1'b0, ~z, 1'b1);
                end
            end
            OP_BEQ, OP_BNE: begin
                e = blank(4'd8); e.alu_src_a = 1'b1; e.alu_op = 2'b01;
                e.pc_source = 2'b01;
                e.pc_en = (op == OP_BEQ) ? z : ~z;
                cyc(e, g, 1'b0, z, 1'b1);
            end
            OP_ADDI: begin
                e = blank(4'd10); e.alu_src_a = 1'b1; e.alu_src_b = 2'b10;
                e.alu_op = 2'b11;
                cyc(e, g, 1'b0, ~z, 1'b1);
                e = blank(4'd11); e.reg_write = 1'b1;
                cyc(e, g, 1'b0, ~z, 1'b1);
            end
            OP_J: begin
                e = blank(4'd9); e.pc_source = 2'b10; e.pc_en = 1'b1;
                cyc(e, g, 1'b0, ~z, 1'b1);
            end
            default: ;
        endcase
    endtask

    // Measure, from the DUT, cycles from a FETCH cycle to the next FETCH.
    // Entered and left at a negedge inside a FETCH cycle.
    task automatic lat_check(input logic [3:0] op, input int want);
        int n;
        opcode = op;
        n = 1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (state == 4'd0) break;
            n++;
        end
        checks++;
        if (n != want) begin
            failures++;
            $display("FAIL latency op=%0d got %0d want %0d", op, n, want);
        end
    endtask

    initial begin
        ctrl_t e;
        // Reset held: everything zero.
        cyc(blank(4'd0), 4'hE, 1'b1, 1'b0, 1'b0);
        cyc(blank(4'd0), 4'hE, 1'b1, 1'b0, 1'b0);

        run_instr(OP_R, 0, 0, 1'b1);
        run_instr(OP_LW, 0, 2, 1'b1);

        // LW interrupted by reset while stalled in MEMRD.
        cyc(fetch_e(1'b1), 4'hE, 1'b1, 1'b0, 1'b1);
        e = blank(4'd1); e.alu_src_b = 2'b10;
        cyc(e, OP_LW, 1'b0, 1'b0, 1'b1);
        e = blank(4'd2); e.alu_src_a = 1'b1; e.alu_src_b = 2'b10;
        cyc(e, 4'hE, 1'b0, 1'b0, 1'b1);
        e = blank(4'd3); e.mem_read = 1'b1; e.i_or_d = 1'b1;
        cyc(e, 4'hE, 1'b0, 1'b0, 1'b1);
        cyc(blank(4'd0), 4'hE, 1'b0, 1'b0, 1'b0);
        cyc(blank(4'd0), 4'hE, 1'b0, 1'b0, 1'b0);
        cyc(fetch_e(1'b0), 4'hE, 1'b0, 1'b0, 1'b1);
        run_instr(OP_R, 0, 0, 1'b1);

        run_instr(OP_BEQ, 0, 0, 1'b1);
        run_instr(OP_BEQ, 0, 0, 1'b0);
        run_instr(OP_BNE, 0, 0, 1'b1);
        run_instr(OP_BNE, 0, 0, 1'b0);
        run_instr(OP_J, 3, 0, 1'b1);
        run_instr(OP_SW, 1, 2, 1'b0);
        run_instr(OP_ADDI, 0, 0, 1'b0);
        run_instr(4'hF, 0, 0, 1'b0);
        run_instr(4'h7, 0, 0, 1'b1);

        // Latencies with mem_ready tied high, hand-computed.
        @(posedge clock);
        #1;
        mem_ready = 1'b1;
        zero = 1'b1;
        opcode = OP_R;
        @(negedge clock);
        checks++;
        if (state !== 4'd0) begin
            failures++;
            $display("FAIL latency_start got st=%0d want 0", state);
        end
        lat_check(OP_R, 4);
        lat_check(OP_ADDI, 4);
        lat_check(OP_LW, 5);
        lat_check(OP_SW, 4);
        lat_check(OP_BEQ, 3);
        lat_check(OP_BNE, 3);
        lat_check(OP_J, 3);
        lat_check(4'hC, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
